// File: rtl/aes128_iter_core_if.sv
// Handshake bus of the iterative AES-128 core: block request in, ciphertext out.
interface aes128_iter_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] plaintext;
  logic [0:127] key;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] en_msg;

  modport master (output in_valid, plaintext, key, out_ready,
                  input  in_ready, out_valid, en_msg);
  modport slave  (input  in_valid, plaintext, key, out_ready,
                  output in_ready, out_valid, en_msg);
endinterface

// File: rtl/aes128_iter_core.sv
// Iterative AES-128 encryptor evaluating UNROLL rounds per clock (1, 2, 5 or 10).
// Optional macro AES_BLKCNT_EN adds a 32-bit completed-block counter output blk_cnt.

module sub_byte (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] m);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), then the FIPS-197 affine map.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] s;
    logic [7:0] acc;
    s   = gmul(x, x);
    acc = s;
    for (int i = 0; i < 6; i++) begin
      s   = gmul(s, s);
      acc = gmul(acc, s);
    end
    return acc;
  endfunction

  logic [7:0] b;
  assign b = ginv(a);
  assign y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
           ^ {b[3:0], b[7:4]} ^ 8'h63;
endmodule

module shift_row (
  input  logic [127:0] d,
  output logic [127:0] q
);
  // Byte 4c+r sits at bits [127-8(4c+r) -: 8]; row r rotates left by r columns.
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign q[127-8*(4*c+r) -: 8] = d[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end
endmodule

module mix_col (
  input  logic [31:0] d,
  output logic [31:0] q
);
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = d;
  assign q[31:24] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
  assign q[23:16] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
  assign q[15:8]  = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
  assign q[7:0]   = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
endmodule

module round_key11 (
  input  logic [127:0]        key,
  output logic [10:0][127:0]  rk
);
  assign rk[0] = key;
  for (genvar i = 1; i <= 10; i++) begin : g_step
    localparam logic [7:0] RCON = (i <= 8) ? 8'(1 << (i-1)) : ((i == 9) ? 8'h1b : 8'h36);
    logic [127:0] kin, k;
    logic [31:0]  w0, w1, w2, w3, rot, sub, n0, n1, n2, n3;
    if (i == 1) begin : g_first
      assign kin = key;
    end else begin : g_next
      assign kin = g_step[i-1].k;
    end
    assign {w0, w1, w2, w3} = kin;
    assign rot = {w3[23:0], w3[31:24]};
    for (genvar b = 0; b < 4; b++) begin : g_sb
      sub_byte u_sb (.a(rot[8*b +: 8]), .y(sub[8*b +: 8]));
    end
    assign n0 = w0 ^ sub ^ {RCON, 24'h0};
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign k  = {n0, n1, n2, n3};
    assign rk[i] = k;
  end
endmodule

module aes128_iter_core #(
  parameter int UNROLL = 1
) (
  input logic clk,
  input logic rst_n,
  aes128_iter_core_if.slave bus
`ifdef AES_BLKCNT_EN
  , output logic [31:0] blk_cnt
`endif
);
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
    $error("aes128_iter_core: UNROLL must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         rnd_q, rnd_nxt;
  logic [127:0]       st_q, key_q, round_out;
  logic [10:0][127:0] rk;
  logic               accept;

  round_key11 u_rk (.key(key_q), .rk(rk));

  // Unrolled round chain; the round that lands on index 10 drops MixColumns.
  for (genvar j = 0; j < UNROLL; j++) begin : g_rnd
    logic [3:0]   idx;
    logic [127:0] din, dout, sb, sr, mc, rkey;
    if (j == 0) begin : g_first
      assign din = st_q;
    end else begin : g_next
      assign din = g_rnd[j-1].dout;
    end
    assign idx = rnd_q + 4'(j + 1);
    for (genvar b = 0; b < 16; b++) begin : g_sb
      sub_byte u_sb (.a(din[8*b +: 8]), .y(sb[8*b +: 8]));
    end
    shift_row u_sr (.d(sb), .q(sr));
    for (genvar c = 0; c < 4; c++) begin : g_mc
      mix_col u_mc (.d(sr[32*c +: 32]), .q(mc[32*c +: 32]));
    end
    assign rkey = (idx <= 4'd10) ? rk[idx] : '0;
    assign dout = ((idx == 4'd10) ? sr : mc) ^ rkey;
  end
  assign round_out = g_rnd[UNROLL-1].dout;

  assign rnd_nxt = rnd_q + 4'(UNROLL);
  assign accept  = (state_q == IDLE) && bus.in_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)       state_d = RUN;
      RUN:     if (rnd_nxt == 4'd10)   state_d = DONE;
      DONE:    if (bus.out_ready)      state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rnd_q   <= '0;
      st_q    <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        key_q <= bus.key;
        st_q  <= bus.plaintext ^ bus.key;
        rnd_q <= '0;
      end else if (state_q == RUN) begin
        st_q  <= round_out;
        rnd_q <= rnd_nxt;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.en_msg    = st_q;

`ifdef AES_BLKCNT_EN
  logic [31:0] blk_cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 blk_cnt_q <= '0;
    else if (state_q == DONE && bus.out_ready)  blk_cnt_q <= blk_cnt_q + 32'd1;
  end
  assign blk_cnt = blk_cnt_q;
`endif
endmodule

// File: tb/tb_aes128_iter_core.sv
// Bench for aes128_iter_core: one instance per legal UNROLL sharing the same stimulus.
`timescale 1ns/1ps
module tb_aes128_iter_core;
  localparam logic [0:127] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [0:127] P2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [0:127] C2  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, out_ready;
  logic [0:127] plaintext, key;
  logic [3:0]   ov, ir;
  logic [0:127] em [4];
`ifdef AES_BLKCNT_EN
  logic [31:0]  bc [4];
`endif
  int n_pass = 0, n_fail = 0, n_tot = 0;
  logic [0:127] sbq [4][$];
  logic [0:127] hold_val [4];

  always #5 clk = ~clk;

  function automatic int unr(input int g);
    return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gi
    aes128_iter_core_if bus ();
    assign bus.in_valid  = in_valid;
    assign bus.plaintext = plaintext;
    assign bus.key       = key;
    assign bus.out_ready = out_ready;
    assign ov[g] = bus.out_valid;
    assign ir[g] = bus.in_ready;
    assign em[g] = bus.en_msg;
    aes128_iter_core #(.UNROLL(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef AES_BLKCNT_EN
      , .blk_cnt (bc[g])
`endif
    );
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pop_chk(input int g, input string tag);
    logic [0:127] exp;
    if (sbq[g].size() == 0) begin
      chk($sformatf("%s_sb_empty_u%0d", tag, unr(g)), 128'(sbq[g].size()), 128'd1);
    end else begin
      exp = sbq[g].pop_front();
      chk($sformatf("%s_ct_u%0d", tag, unr(g)), em[g], exp);
    end
  endtask

  // Accept one block, then watch 11 edges: out_valid must appear exactly at 10/UNROLL.
  task automatic run_block(input logic [0:127] pt, input logic [0:127] k,
                           input logic [0:127] exp, input bit glitch, input string tag);
    plaintext = pt; key = k; in_valid = 1'b1; out_ready = 1'b1;
    for (int g = 0; g < 4; g++) sbq[g].push_back(exp);
    step();
    in_valid = 1'b0;
    if (glitch) begin
      plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
      key       = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_valid  = 1'b1;
    end
    for (int c = 1; c <= 11; c++) begin
      step();
      in_valid = 1'b0;
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("%s_ov_u%0d_c%0d", tag, unr(g), c), 128'(ov[g]), 128'(c == 10 / unr(g)));
        if (ov[g]) pop_chk(g, tag);
      end
    end
    chk({tag, "_idle"}, 128'(ir), 128'hF);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
    #1;
    chk("rst_out_valid", 128'(ov), 128'h0);
    chk("rst_in_ready",  128'(ir), 128'hF);
    for (int g = 0; g < 4; g++) chk($sformatf("rst_en_msg_u%0d", unr(g)), em[g], 128'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_block(P1, K1, C1, 1'b0, "kat1");
    run_block(P2, K2, C2, 1'b0, "kat2");

    // Consumer stalls for 20 clocks with the result pending.
    plaintext = P2; key = K2; in_valid = 1'b1; out_ready = 1'b0;
    for (int g = 0; g < 4; g++) sbq[g].push_back(C2);
    step();
    in_valid = 1'b0;
    repeat (10) step();
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("hold_ov_u%0d", unr(g)), 128'(ov[g]), 128'd1);
      pop_chk(g, "hold");
      hold_val[g] = em[g];
    end
    for (int i = 0; i < 20; i++) begin
      step();
      for (int g = 0; g < 4; g++) begin
        chk($sformatf("hold_stable_u%0d_%0d", unr(g), i), em[g], hold_val[g]);
        chk($sformatf("hold_ov_u%0d_%0d", unr(g), i), 128'(ov[g]), 128'd1);
      end
      chk($sformatf("hold_in_ready_%0d", i), 128'(ir), 128'h0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_in_ready", 128'(ir), 128'hF);
    chk("release_ov", 128'(ov), 128'h0);

    run_block(P1, K1, C1, 1'b1, "glitch");

    // Reset lands with the UNROLL=1 core at rnd=4; the block is discarded.
    plaintext = P1; key = K1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ov", 128'(ov), 128'h0);
    chk("arst_in_ready", 128'(ir), 128'hF);
    for (int g = 0; g < 4; g++) chk($sformatf("arst_en_msg_u%0d", unr(g)), em[g], 128'h0);
    @(negedge clk);
    chk("arst_hold_ov", 128'(ov), 128'h0);
    rst_n = 1'b1;
    run_block(P2, K2, C2, 1'b0, "post_rst");

`ifdef AES_BLKCNT_EN
    force gi[0].u_dut.blk_cnt_q = 32'hFFFFFFFE;
    #1 release gi[0].u_dut.blk_cnt_q;
    @(negedge clk);
    run_block(P1, K1, C1, 1'b0, "cnt0");
    chk("blk_cnt_0", 128'(bc[0]), 128'hFFFFFFFF);
    run_block(P2, K2, C2, 1'b0, "cnt1");
    chk("blk_cnt_1", 128'(bc[0]), 128'h0);
    run_block(P1, K1, C1, 1'b0, "cnt2");
    chk("blk_cnt_2", 128'(bc[0]), 128'h1);
`endif

    for (int g = 0; g < 4; g++)
      chk($sformatf("sb_drained_u%0d", unr(g)), 128'(sbq[g].size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/aes128_iter_core.md
AES128_ITER_CORE -- requirements
Module: aes128_iter_core

Interface
REQ-001 The block SHALL have parameter UNROLL, default 1, meaning AES rounds evaluated per clock; legal values are 1, 2, 5 and 10, and any other value SHALL cause an elaboration error.
REQ-002 The block SHALL have a port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have a port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have a port in_valid, input, 1 bit: plaintext and key are presented.
REQ-005 The block SHALL have a port in_ready, output, 1 bit: the core can accept a block.
REQ-006 The block SHALL have a port plaintext, input, 128 bits [0:127]: bit 0 is the MSB, byte 0 = bits [0:7].
REQ-007 The block SHALL have a port key, input, 128 bits [0:127]: cipher key, same byte order as plaintext.
REQ-008 The block SHALL have a port out_valid, output, 1 bit: en_msg holds a valid ciphertext.
REQ-009 The block SHALL have a port out_ready, input, 1 bit: the consumer accepts en_msg.
REQ-010 The block SHALL have a port en_msg, output, 128 bits [0:127]: ciphertext.

Function
REQ-011 The core SHALL implement an FSM with states IDLE, RUN and DONE; reset state IDLE.
REQ-012 in_ready SHALL be 1 only in IDLE.
REQ-013 A block is accepted on a rising edge with in_valid=1 and in_ready=1: at that edge the core latches key and loads state = plaintext XOR key, clears round counter rnd (4 bits), and moves to RUN.
REQ-014 In RUN, each clock SHALL apply UNROLL consecutive rounds to state; a full round is SubBytes, ShiftRows, MixColumns, then XOR with round key (rnd+1).
REQ-015 Round 10 SHALL omit MixColumns; it SHALL occur only as the last round of the final RUN cycle.
REQ-016 Round keys 1..10 SHALL derive from the latched key per FIPS-197 expansion and SHALL use the existing sub_byte, shift_row, mix_col and round_key11 blocks.
REQ-017 rnd SHALL advance by UNROLL per RUN cycle; when rnd+UNROLL = 10, the FSM SHALL move to DONE.
REQ-018 out_valid SHALL be 1 exactly in DONE, first asserted 10/UNROLL clocks after the accept edge.
REQ-019 en_msg SHALL equal the final state and SHALL remain stable while out_valid=1.
REQ-020 In DONE, out_ready=1 at a rising edge SHALL complete the transfer and return the FSM to IDLE.
REQ-021 While out_ready=0, DONE and en_msg SHALL hold indefinitely.
REQ-022 in_valid and input changes outside IDLE SHALL be ignored; plaintext and key SHALL be sampled only at the accept edge.
REQ-023 Maximum throughput SHALL be one block per 10/UNROLL + 2 clocks (accept, RUN cycles, DONE).

Reset
REQ-024 Assertion of rst_n=0 SHALL immediately force: FSM to IDLE, rnd=0, state=0, latched key=0, en_msg=0, out_valid=0 and in_ready=1, with no clock required.
REQ-025 A reset asserted during RUN or DONE SHALL discard the block in flight; no out_valid SHALL be produced for it.
REQ-026 Deassertion of rst_n SHALL take effect at the next rising clk edge; the first accept is possible on that edge.

Configuration
REQ-027 With macro AES_BLKCNT_EN defined, the core SHALL add output blk_cnt (32 bits).
REQ-028 With AES_BLKCNT_EN defined, blk_cnt SHALL reset to 0, increment by 1 on each completed out_valid and out_ready transfer, and wrap from 0xFFFFFFFF to 0.
REQ-029 Without AES_BLKCNT_EN, the blk_cnt port and its counter SHALL be absent, with all other behaviour unchanged.

Verification
REQ-030 For each UNROLL in {1,2,5,10}, with key=000102030405060708090a0b0c0d0e0f and pt=00112233445566778899aabbccddeeff, the bench SHALL check en_msg=69c4e0d86a7b0430d8cdb78070b4c55a and out_valid exactly 10/UNROLL clocks after accept.
REQ-031 With key=2b7e151628aed2a6abf7158809cf4f3c and pt=3243f6a8885a308d313198a2e0370734, the bench SHALL check en_msg=3925841d02dc09fbdc118597196a0b32.
REQ-032 The bench SHALL hold out_ready=0 for 20 clocks after out_valid and check that en_msg is stable and in_ready=0; it SHALL then pulse out_ready and check in_ready=1 on the next clock.
REQ-033 The bench SHALL change plaintext and key and pulse in_valid during RUN, and check that the ciphertext still matches the originally accepted block.
REQ-034 The bench SHALL assert rst_n=0 mid-RUN with UNROLL=1 at rnd=4, and check out_valid=0, en_msg=0 and in_ready=1 asynchronously, and that a following block completes correctly.
REQ-035 With AES_BLKCNT_EN defined, the bench SHALL force blk_cnt to 0xFFFFFFFE, run 3 blocks, and check the sequence FFFFFFFF, 00000000, 00000001.
